tt_capture: RTL
===============

TT_CAPTURE -- requirements
Module: tt_capture

Interface
REQ-001 SHALL have parameter N_IN, default 6: number of inputs of the combinational function under sweep.
REQ-002 SHALL have parameter LAT, default 0: extra settle cycles per vector before y is sampled (0..15).
REQ-003 SHALL have clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have start, input, 1: request a full sweep; sampled only in IDLE.
REQ-006 SHALL have golden, input, 2**N_IN: expected truth table; bit i = expected y for vector i.
REQ-007 SHALL have x, output, N_IN: vector driven to the function inputs (x[0] maps to x0).
REQ-008 SHALL have y, input, 1: function output (y0).
REQ-009 SHALL have busy, output, 1: high from the cycle after start is accepted until done.
REQ-010 SHALL have done, output, 1: one-cycle pulse when the sweep completes.
REQ-011 SHALL have tt, output, 2**N_IN: captured truth table.
REQ-012 SHALL have match, output, 1: tt == golden; valid from done, held until next start.
REQ-013 SHALL have mismatch_cnt, output, N_IN+1: popcount(tt ^ golden), same validity as match.
REQ-014 SHALL have sig, output, 16: MISR signature (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE with start=1 SHALL move to SETTLE (or SAMPLE if LAT=0) with idx=0, clear tt, mismatch_cnt and sig.
REQ-017 x SHALL equal idx in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-018 SETTLE SHALL last exactly LAT cycles; SAMPLE SHALL last 1 cycle, so each vector occupies LAT+1 cycles.
REQ-019 In SAMPLE, tt[idx] SHALL take y, and mismatch_cnt SHALL increment when y != golden[idx].
REQ-020 From SAMPLE with idx == 2**N_IN-1, the FSM SHALL move to DONE; otherwise it SHALL increment idx and re-enter SETTLE/SAMPLE.
REQ-021 idx SHALL NOT wrap; the last vector is followed only by DONE.
REQ-022 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-023 For start accepted at edge k, done SHALL be high in cycle k+1+2**N_IN*(LAT+1).
REQ-024 start SHALL be ignored while busy or in DONE; a request is not queued.
REQ-025 golden SHALL be held stable by the driver during busy; it is used per-bit at sample time.
REQ-026 match SHALL be registered as (mismatch_cnt == 0) in DONE; it SHALL be 0 while busy.
REQ-027 tt, match, mismatch_cnt and sig SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-028 rst SHALL force IDLE, idx=0, x=0, busy=0, done=0, tt=0, match=0, mismatch_cnt=0 and sig=0, with no clock required.
REQ-029 rst asserted mid-sweep SHALL abort the sweep without a done pulse.

Configuration
REQ-030 With macro TT_CAPTURE_MISR_EN defined, sig SHALL be a 16-bit MISR (polynomial x^16+x^12+x^5+1, seed 0xFFFF at start) updated with y in every SAMPLE.
REQ-031 Without TT_CAPTURE_MISR_EN, sig SHALL be tied to 0 and no MISR logic SHALL be built.

Structure
REQ-032 Package tt_capture_pkg SHALL hold the FSM state enum, MISR polynomial and seed constants, and the LAT width constant.
REQ-033 The MISR SHALL be a sub-module tt_misr, instantiated only under TT_CAPTURE_MISR_EN.

Verification
REQ-034 y=x[0], golden=64'hAAAAAAAAAAAAAAAA, LAT=0, start at edge k -> done in cycle k+65, tt=golden, match=1, mismatch_cnt=0.
REQ-035 y=x[0], golden=0 -> match=0, mismatch_cnt=32.
REQ-036 LAT=2, y=0, golden=0 -> x holds each value for 3 cycles, done in cycle k+193, match=1.
REQ-037 start pulsed again at idx=5 -> no restart, single done pulse, x sequence unbroken.
REQ-038 rst asserted while idx=10 -> all outputs 0 immediately, no done pulse; a new start then sweeps from x=0.
REQ-039 MISR_EN build with y=1 constant -> sig equals the reference model after 64 shifts from 0xFFFF; non-MISR build -> sig=0.

Source files
------------

// File: rtl/tt_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_capture_pkg
//  Description : Shared types and constants for the truth-table capture block:
//                sweep FSM state encoding, MISR polynomial/seed and the width
//                of the per-vector settle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_t;

    // Settle counter width; LAT is limited to 0..15.
    localparam int          c_LAT_W     = 4;

    // x^16 + x^12 + x^5 + 1 (the x^16 term is implicit in the shift-out).
    localparam logic [15:0] c_MISR_POLY = 16'h1021;
    localparam logic [15:0] c_MISR_SEED = 16'hFFFF;

endpackage : tt_capture_pkg
`default_nettype wire

// File: rtl/tt_misr.sv
`default_nettype none
// ============================================================================
//  Module      : tt_misr
//  Description : Single-input 16-bit signature register. Seeded on request,
//                then folds one data bit per shift into the signature.
//  Ports       : clk, rst (async, active high)
//                seed_i   - load the seed value (has priority over shift)
//                shift_i  - absorb data_i this cycle
//                data_i   - serial input bit
//                sig_o    - current signature
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_misr
    import tt_capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_i,
    input  logic        shift_i,
    input  logic        data_i,
    output logic [15:0] sig_o
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;
    logic        w_fb;

    always_comb begin
        sig_d = sig_q;
        // Bit leaving the top combined with the new input decides whether the
        // polynomial is folded back in.
        w_fb  = sig_q[15] ^ data_i;
        if (seed_i) begin
            sig_d = c_MISR_SEED;
        end else if (shift_i) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (w_fb ? c_MISR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule : tt_misr
`default_nettype wire

// File: rtl/tt_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tt_capture
//  Description : Sweeps every input vector of an N_IN-input combinational
//                function, waits LAT settle cycles per vector, samples y into
//                a truth table and compares it bit-by-bit with golden.
//  Ports       : clk, rst (async, active high)
//                start        - begin a sweep (only honoured when idle)
//                golden       - expected truth table, bit i for vector i
//                x            - vector under test (0 when not sweeping)
//                y            - function output
//                busy, done   - sweep in progress / one-cycle completion pulse
//                tt           - captured truth table
//                match        - tt equals golden (valid from done)
//                mismatch_cnt - number of differing bits
//                sig          - MISR signature of the sampled y stream
//  Config      : TT_CAPTURE_MISR_EN - build the signature register; without
//                it sig is constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_capture
    import tt_capture_pkg::*;
#(
    parameter int N_IN = 6,
    parameter int LAT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   golden,
    output logic [N_IN-1:0]      x,
    input  logic                 y,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt,
    output logic                 match,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [15:0]          sig
);

    localparam int               c_VEC      = 2**N_IN;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = (LAT == 0) ? '0 : c_LAT_W'(LAT - 1);
    // With no settle time each vector goes straight to sampling.
    localparam tt_state_t        c_FIRST    = (LAT == 0) ? ST_SAMPLE : ST_SETTLE;

    tt_state_t           state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [c_LAT_W-1:0]  lat_q, lat_d;
    logic [c_VEC-1:0]    tt_q, tt_d;
    logic [N_IN:0]       cnt_q, cnt_d;
    logic                match_q, match_d;
    logic                w_last;
    logic                w_active;

    assign w_last   = (idx_q == {N_IN{1'b1}});
    assign w_active = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        tt_d    = tt_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = c_FIRST;
                    idx_d   = '0;
                    lat_d   = '0;
                    tt_d    = '0;
                    cnt_d   = '0;
                    match_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (lat_q == c_LAT_LAST) begin
                    state_d = ST_SAMPLE;
                    lat_d   = '0;
                end else begin
                    lat_d   = lat_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                tt_d[idx_q] = y;
                if (y != golden[idx_q]) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (w_last) begin
                    state_d = ST_DONE;
                    // Uses the count including this final sample so match is
                    // already valid while done is high.
                    match_d = (cnt_d == '0);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = c_FIRST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            tt_q    <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            tt_q    <= tt_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign x            = w_active ? idx_q : '0;
    assign busy         = w_active;
    assign done         = (state_q == ST_DONE);
    assign tt           = tt_q;
    assign match        = match_q;
    assign mismatch_cnt = cnt_q;

`ifdef TT_CAPTURE_MISR_EN
    logic w_seed;
    logic w_shift;

    assign w_seed  = (state_q == ST_IDLE) && start;
    assign w_shift = (state_q == ST_SAMPLE);

    tt_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .seed_i  (w_seed),
        .shift_i (w_shift),
        .data_i  (y),
        .sig_o   (sig)
    );
`else
    assign sig = 16'h0000;
`endif

endmodule : tt_capture
`default_nettype wire
